regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-port integer register file with a per-register pending-write scoreboard, sitting between decode (reads, destination issue) and writeback in the pipelined core. It replaces the single busy bit per register with a saturating outstanding-write counter, supports several read and writeback ports and a pipeline flush, and reports per-port and aggregate RAW hazards. Optional write-through bypass forwards same-cycle writeback data to readers.

## Interface
- ADDR_WIDTH, 5, register index width; NREGS = 2**ADDR_WIDTH
- DATA_WIDTH, 64, register width
- NUM_RD, 2, read ports
- NUM_WB, 2, writeback ports; higher index = younger
- PEND_WIDTH, 2, pending counter width; max outstanding writes per register PMAX = 2**PEND_WIDTH-1
- RESET_VALUE, 64'hDEADBEEFDEADBEEF, reset contents of registers other than x0 and x2

- clk  in  1  clock; reset reset, synchronous, active-high; clock clk
- reset  in  1  synchronous, active-high
- stackptr  in  DATA_WIDTH  value loaded into x2 at reset
- rd_en  in  NUM_RD  read port p in use (hazard qualifier)
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data
- rd_busy  out  NUM_RD  port p reads a register with pending writes
- raw_dependency  out  1  OR over p of rd_en[p] & rd_busy[p]
- issue_valid  in  1  decode issues an instruction writing issue_addr
- issue_addr  in  ADDR_WIDTH  destination of issued instruction
- issue_ready  out  1  counter[issue_addr] < PMAX, or issue_addr==0
- wb_valid  in  NUM_WB  writeback port w valid
- wb_addr  in  NUM_WB*ADDR_WIDTH  packed writeback indices
- wb_data  in  NUM_WB*DATA_WIDTH  packed writeback data
- flush  in  1  discard all pending-write tracking
- write_complete  out  1  registered: any wb_valid accepted on previous edge

## Operation
- Storage: NREGS x DATA_WIDTH array plus NREGS x PEND_WIDTH counters. x0 reads 0, never written, never busy, counter fixed 0.
- Reset (edge with reset=1): x0=0, x2=stackptr, all others RESET_VALUE; all counters 0; write_complete 0. Reset overrides every other input that edge.
- Issue: issue_valid & issue_ready & addr!=0 increments counter[issue_addr]. Issue with issue_ready=0 is dropped; upstream must hold.
- Writeback: each wb_valid[w] with addr!=0 writes wb_data[w] and decrements counter[wb_addr[w]] by one, saturating at 0 (orphan writeback never underflows). Two ports to same address: higher w wins data; counter decrements by 2 (saturating).
- Same-edge issue and writeback to same register: net counter change = +1 - (number of writebacks), saturating at 0/PMAX.
- Flush: all counters cleared to 0 on that edge; issue ignored; writeback data that edge still written.
- rd_busy[p] = counter[rd_addr[p]] != 0 (current state). rd_data[p] = array[rd_addr[p]], combinational.

## Timing
- Reads combinational, zero latency; writes visible to reads the cycle after the edge (without bypass).
- issue_ready combinational from issue_addr and current counter only; does not depend on same-cycle writeback.
- write_complete high exactly one cycle after an edge with any wb_valid bit set; otherwise 0.
- Counter/array update in same edge; no multi-cycle paths.

## Configuration
- RF_BYPASS_EN defined: for each read port, if any wb_valid[w] targets rd_addr[p] (!=0) this cycle, rd_data[p] = youngest matching wb_data, and rd_busy[p] = next-state counter != 0 (ignoring same-cycle issue and flush).
- Undefined: rd_data/rd_busy strictly from current array/counter; reader sees the new value one cycle later.

## Test plan
- Reset with stackptr=64'h8000_0000: x2 reads 64'h8000_0000, x5 reads 64'hDEADBEEFDEADBEEF, x0 reads 0, all rd_busy 0, write_complete 0.
- Issue x7 three times (PEND_WIDTH=2): counter=3, issue_ready=0 for x7, fourth issue dropped; three wb to x7 -> rd_busy clears after third, data = last written.
- Same edge issue x9 and wb x9 (counter 1): counter stays 1, rd_busy[x9]=1; wb_valid=2'b11 both to x9 with 5/6 -> x9=6, counter 0.
- Read x4 while wb x4=64'h1234 (counter 1): with RF_BYPASS_EN rd_data=64'h1234, rd_busy=0 same cycle; without, old value and rd_busy=1, correct next cycle.
- Flush with counters nonzero and wb x3=64'hAA same edge: all rd_busy 0 next cycle, x3=64'hAA; subsequent wb to x3 leaves counter 0 (no underflow).
- Write to x0 with 64'hFF and issue x0: x0 reads 0, never busy, issue_ready=1, write_complete=1 next cycle.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
// Bundles the decode/writeback side signals of the register file scoreboard.
//   master : the pipeline (decode + writeback) driving reads, issue and wb
//   slave  : the register file itself
// Signals:
//   rd_en/rd_addr -> rd_data/rd_busy/raw_dependency   read ports + hazards
//   issue_valid/issue_addr -> issue_ready              destination issue
//   wb_valid/wb_addr/wb_data                           writeback ports
//   flush                                              drop pending tracking
//   write_complete                                     wb accepted last edge
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64,
   parameter int NUM_RD     = 2,
   parameter int NUM_WB     = 2
);
   logic [NUM_RD-1:0]            rd_en;
   logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]            rd_busy;
   logic                         raw_dependency;
   logic                         issue_valid;
   logic [ADDR_WIDTH-1:0]        issue_addr;
   logic                         issue_ready;
   logic [NUM_WB-1:0]            wb_valid;
   logic [NUM_WB*ADDR_WIDTH-1:0] wb_addr;
   logic [NUM_WB*DATA_WIDTH-1:0] wb_data;
   logic                         flush;
   logic                         write_complete;

   modport master (
      output rd_en, rd_addr, issue_valid, issue_addr,
             wb_valid, wb_addr, wb_data, flush,
      input  rd_data, rd_busy, raw_dependency, issue_ready, write_complete
   );

   modport slave (
      input  rd_en, rd_addr, issue_valid, issue_addr,
             wb_valid, wb_addr, wb_data, flush,
      output rd_data, rd_busy, raw_dependency, issue_ready, write_complete
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Multi-port integer register file with a saturating pending-write counter
// per register. Decode issues destinations (counter +1), writeback ports
// write data and retire pending writes (counter -1 each, floor 0), flush
// clears all counters. Reads and hazard flags are combinational.
//
// Ports:
//   clk       clock
//   reset     synchronous, active-high; x0=0, x2=stackptr, others RESET_VALUE
//   stackptr  value loaded into x2 at reset
//   bus       regfile_scoreboard_if.slave (reads, issue, writeback, flush,
//             hazards, write_complete)
//
// Build option:
//   RF_BYPASS_EN  when defined, a reader whose address matches a same-cycle
//                 writeback sees the youngest writeback data, and its busy
//                 flag reflects the counter after that writeback retires.
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int                   ADDR_WIDTH  = 5,
   parameter int                   DATA_WIDTH  = 64,
   parameter int                   NUM_RD      = 2,
   parameter int                   NUM_WB      = 2,
   parameter int                   PEND_WIDTH  = 2,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 64'hDEADBEEFDEADBEEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] stackptr,
   regfile_scoreboard_if.slave   bus
);

   localparam int NREGS = 2 ** ADDR_WIDTH;
   localparam int PMAX  = 2 ** PEND_WIDTH - 1;
   localparam int HIT_W = $clog2(NUM_WB + 1);

   logic [DATA_WIDTH-1:0] regs     [NREGS];
   logic [PEND_WIDTH-1:0] pend     [NREGS];
   logic [PEND_WIDTH-1:0] pend_nxt [NREGS];
   logic [HIT_W-1:0]      wb_hits  [NREGS];

   logic                         issue_ready_c;
   logic                         issue_go;
   logic                         write_complete_q;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_data_c;
   logic [NUM_RD-1:0]            rd_busy_c;

   // Counter update clamped to [0, PMAX]: orphan writebacks never wrap.
   function automatic logic [PEND_WIDTH-1:0] sat_update(
      input logic [PEND_WIDTH-1:0] cnt,
      input logic                  inc,
      input logic [HIT_W-1:0]      dec
   );
      int v;
      v = int'(cnt) + int'(inc) - int'(dec);
      if (v < 0)
         v = 0;
      else if (v > PMAX)
         v = PMAX;
      return PEND_WIDTH'(v);
   endfunction

   // Number of writeback ports retiring each register this cycle (x0 never).
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         wb_hits[r] = '0;
         for (int w = 0; w < NUM_WB; w++) begin
            if (r != 0 && bus.wb_valid[w] &&
                bus.wb_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
               wb_hits[r] = wb_hits[r] + HIT_W'(1);
         end
      end
   end

   // issue_ready looks only at the current counter, not same-cycle retires.
   assign issue_ready_c = (bus.issue_addr == '0) ||
                          (pend[bus.issue_addr] != PEND_WIDTH'(PMAX));
   assign issue_go      = bus.issue_valid && issue_ready_c &&
                          (bus.issue_addr != '0) && !bus.flush;

   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         pend_nxt[r] = '0;
         if (r != 0 && !bus.flush)
            pend_nxt[r] = sat_update(pend[r],
                                     issue_go && (bus.issue_addr == ADDR_WIDTH'(r)),
                                     wb_hits[r]);
      end
   end

   // ---- edge: counters, array, write_complete ----
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++)
            pend[r] <= '0;
         write_complete_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++)
            pend[r] <= pend_nxt[r];
         write_complete_q <= |bus.wb_valid;
      end
   end

   // Ascending port order: the youngest (highest index) writer wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++)
            regs[r] <= (r == 2) ? stackptr : RESET_VALUE;
         regs[0] <= '0;
      end else begin
         for (int w = 0; w < NUM_WB; w++) begin
            if (bus.wb_valid[w] && bus.wb_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)
               regs[bus.wb_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wb_data[w*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // ---- combinational read ports ----
   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         logic [ADDR_WIDTH-1:0] a;
         logic [DATA_WIDTH-1:0] d;
         a = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
         d = (a == '0) ? '0 : regs[a];
`ifdef RF_BYPASS_EN
         for (int w = 0; w < NUM_WB; w++) begin
            if (a != '0 && bus.wb_valid[w] &&
                bus.wb_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == a)
               d = bus.wb_data[w*DATA_WIDTH +: DATA_WIDTH];
         end
         // Busy after this cycle's retires; same-cycle issue/flush ignored.
         rd_busy_c[p] = (sat_update(pend[a], 1'b0, wb_hits[a]) != '0);
`else
         rd_busy_c[p] = (pend[a] != '0);
`endif
         rd_data_c[p*DATA_WIDTH +: DATA_WIDTH] = d;
      end
   end

   assign bus.rd_data        = rd_data_c;
   assign bus.rd_busy        = rd_busy_c;
   assign bus.raw_dependency = |(bus.rd_en & rd_busy_c);
   assign bus.issue_ready    = issue_ready_c;
   assign bus.write_complete = write_complete_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
   localparam int AW    = 5;
   localparam int DW    = 64;
   localparam int NRD   = 2;
   localparam int NWB   = 2;
   localparam int PMAX  = 3;
   localparam int NREGS = 32;
   localparam logic [63:0] RV = 64'hDEADBEEFDEADBEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] stackptr;

   always #5 clk = ~clk;

   regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WB(NWB)) bus();

   regfile_scoreboard dut (
      .clk      (clk),
      .reset    (reset),
      .stackptr (stackptr),
      .bus      (bus)
   );

   // Reference model: register contents and outstanding-write counts.
   logic [63:0] m_regs [NREGS];
   int          m_pend [NREGS];
   logic        m_wc;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      bus.rd_en       = '0;
      bus.issue_valid = 1'b0;
      bus.issue_addr  = '0;
      bus.wb_valid    = '0;
      bus.flush       = 1'b0;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a);
      bus.rd_en[p] = 1'b1;
      bus.rd_addr[p*AW +: AW] = a;
   endtask

   task automatic set_wb(input int w, input logic [AW-1:0] a, input logic [63:0] d);
      bus.wb_valid[w] = 1'b1;
      bus.wb_addr[w*AW +: AW] = a;
      bus.wb_data[w*DW +: DW] = d;
   endtask

   task automatic set_issue(input logic [AW-1:0] a);
      bus.issue_valid = 1'b1;
      bus.issue_addr  = a;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS-1));
      return AW'($urandom_range(0, 5));
   endfunction

   // ---------------- reference model ----------------
   function automatic int wb_count(input int a);
      int c = 0;
      for (int w = 0; w < NWB; w++)
         if (a != 0 && bus.wb_valid[w] && int'(bus.wb_addr[w*AW +: AW]) == a) c++;
      return c;
   endfunction

   function automatic bit m_issue_ready();
      int a = int'(bus.issue_addr);
      return (a == 0) || (m_pend[a] < PMAX);
   endfunction

   function automatic logic [63:0] exp_data(input int a);
      logic [63:0] d;
      if (a == 0) return 64'd0;
      d = m_regs[a];
`ifdef RF_BYPASS_EN
      for (int w = 0; w < NWB; w++)
         if (bus.wb_valid[w] && int'(bus.wb_addr[w*AW +: AW]) == a) d = bus.wb_data[w*DW +: DW];
`endif
      return d;
   endfunction

   function automatic bit exp_busy(input int a);
      int v;
      if (a == 0) return 1'b0;
      v = m_pend[a];
`ifdef RF_BYPASS_EN
      v = v - wb_count(a);
      if (v < 0) v = 0;
`endif
      return v != 0;
   endfunction

   task automatic model_edge();
      bit go;
      int nxt [NREGS];
      int v;
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = (r == 2) ? stackptr : RV;
            m_pend[r] = 0;
         end
         m_regs[0] = 64'd0;
         m_wc = 1'b0;
         return;
      end
      go = bus.issue_valid && m_issue_ready() && bus.issue_addr != 0 && !bus.flush;
      for (int r = 0; r < NREGS; r++) begin
         if (bus.flush || r == 0) nxt[r] = 0;
         else begin
            v = m_pend[r] + ((go && int'(bus.issue_addr) == r) ? 1 : 0) - wb_count(r);
            if (v < 0) v = 0;
            if (v > PMAX) v = PMAX;
            nxt[r] = v;
         end
      end
      for (int w = 0; w < NWB; w++)
         if (bus.wb_valid[w] && bus.wb_addr[w*AW +: AW] != 0)
            m_regs[bus.wb_addr[w*AW +: AW]] = bus.wb_data[w*DW +: DW];
      for (int r = 0; r < NREGS; r++) m_pend[r] = nxt[r];
      m_wc = |bus.wb_valid;
   endtask

   // Inputs are applied after the falling edge; the model advances with the rising edge.
   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      stackptr = 64'h8000_0000;
      reset = 1'b1;
      set_issue(5);
      set_wb(0, 5, 64'h55);
      tick();
      reset = 1'b0;
      idle();
      tick();
      set_rd(0, 2); set_rd(1, 5); #1;
      n_checks++; if (bus.rd_data[0 +: 64] !== 64'h8000_0000) begin n_fail++; $display("FAIL reset_x2 got=%h exp=%h", bus.rd_data[0 +: 64], 64'h8000_0000); end
      n_checks++; if (bus.rd_data[64 +: 64] !== RV) begin n_fail++; $display("FAIL reset_x5 got=%h exp=%h", bus.rd_data[64 +: 64], RV); end
      n_checks++; if (bus.write_complete !== 1'b0) begin n_fail++; $display("FAIL reset_wc got=%b exp=0", bus.write_complete); end
      set_rd(0, 0); set_rd(1, 31); #1;
      n_checks++; if (bus.rd_data[0 +: 64] !== 64'd0) begin n_fail++; $display("FAIL reset_x0 got=%h exp=0", bus.rd_data[0 +: 64]); end
      n_checks++; if (bus.rd_data[64 +: 64] !== RV) begin n_fail++; $display("FAIL reset_x31 got=%h exp=%h", bus.rd_data[64 +: 64], RV); end
      for (int a = 0; a < NREGS; a += 2) begin
         set_rd(0, AW'(a)); set_rd(1, AW'(a+1)); #1;
         n_checks++; if (bus.rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_busy x%0d got=%b exp=00", a, bus.rd_busy); end
      end
      n_checks++; if (bus.raw_dependency !== 1'b0) begin n_fail++; $display("FAIL reset_raw got=%b exp=0", bus.raw_dependency); end
   endtask

   task automatic test_issue_saturation();
      logic [63:0] d;
      for (int i = 0; i < 3; i++) begin
         idle(); set_issue(7); #1;
         n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_ready%0d got=%b exp=1", i, bus.issue_ready); end
         tick();
      end
      idle(); set_issue(7); #1;
      n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_full got=%b exp=0", bus.issue_ready); end
      tick();
      for (int i = 0; i < 3; i++) begin
         d = {$urandom, $urandom};
         idle(); set_wb(0, 7, d); tick();
         idle(); set_rd(0, 7); #1;
         n_checks++; if (bus.rd_busy[0] !== (i < 2)) begin n_fail++; $display("FAIL sat_busy%0d got=%b exp=%b", i, bus.rd_busy[0], i < 2); end
         n_checks++; if (bus.rd_data[0 +: 64] !== d) begin n_fail++; $display("FAIL sat_data%0d got=%h exp=%h", i, bus.rd_data[0 +: 64], d); end
      end
   endtask

   task automatic test_same_edge();
      idle(); set_issue(9); tick();
      idle(); set_issue(9); set_wb(0, 9, 64'h77); tick();
      idle(); set_rd(0, 9); #1;
      n_checks++; if (bus.rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL same_busy got=%b exp=1", bus.rd_busy[0]); end
      n_checks++; if (bus.raw_dependency !== 1'b1) begin n_fail++; $display("FAIL same_raw got=%b exp=1", bus.raw_dependency); end
      idle(); set_wb(0, 9, 64'd5); set_wb(1, 9, 64'd6); tick();
      idle(); set_rd(0, 9); #1;
      n_checks++; if (bus.rd_data[0 +: 64] !== 64'd6) begin n_fail++; $display("FAIL dual_data got=%h exp=6", bus.rd_data[0 +: 64]); end
      n_checks++; if (bus.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL dual_busy got=%b exp=0", bus.rd_busy[0]); end
      n_checks++; if (bus.write_complete !== 1'b1) begin n_fail++; $display("FAIL dual_wc got=%b exp=1", bus.write_complete); end
   endtask

   task automatic test_bypass();
      idle(); set_issue(4); tick();
      idle(); set_rd(1, 4); set_wb(0, 4, 64'h1234); #1;
`ifdef RF_BYPASS_EN
      n_checks++; if (bus.rd_data[64 +: 64] !== 64'h1234) begin n_fail++; $display("FAIL byp_data got=%h exp=1234", bus.rd_data[64 +: 64]); end
      n_checks++; if (bus.rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL byp_busy got=%b exp=0", bus.rd_busy[1]); end
`else
      n_checks++; if (bus.rd_data[64 +: 64] !== RV) begin n_fail++; $display("FAIL byp_data got=%h exp=%h", bus.rd_data[64 +: 64], RV); end
      n_checks++; if (bus.rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL byp_busy got=%b exp=1", bus.rd_busy[1]); end
`endif
      tick();
      idle(); set_rd(1, 4); #1;
      n_checks++; if (bus.rd_data[64 +: 64] !== 64'h1234) begin n_fail++; $display("FAIL byp_next_data got=%h exp=1234", bus.rd_data[64 +: 64]); end
      n_checks++; if (bus.raw_dependency !== 1'b0) begin n_fail++; $display("FAIL byp_next_raw got=%b exp=0", bus.raw_dependency); end
   endtask

   task automatic test_flush();
      idle(); set_issue(3);  tick();
      idle(); set_issue(11); tick();
      idle(); set_issue(11); tick();
      idle(); bus.flush = 1'b1; set_issue(12); set_wb(0, 3, 64'hAA); tick();
      idle();
      for (int a = 0; a < NREGS; a += 2) begin
         set_rd(0, AW'(a)); set_rd(1, AW'(a+1)); #1;
         n_checks++; if (bus.rd_busy !== 2'b00) begin n_fail++; $display("FAIL flush_busy x%0d got=%b exp=00", a, bus.rd_busy); end
      end
      set_rd(0, 3); #1;
      n_checks++; if (bus.rd_data[0 +: 64] !== 64'hAA) begin n_fail++; $display("FAIL flush_data got=%h exp=aa", bus.rd_data[0 +: 64]); end
      idle(); set_wb(1, 3, 64'hBB); tick();
      idle(); set_rd(0, 3); #1;
      n_checks++; if (bus.rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL orphan_busy got=%b exp=0", bus.rd_busy[0]); end
      n_checks++; if (bus.rd_data[0 +: 64] !== 64'hBB) begin n_fail++; $display("FAIL orphan_data got=%h exp=bb", bus.rd_data[0 +: 64]); end
   endtask

   task automatic test_x0();
      for (int i = 0; i < 4; i++) begin
         idle(); set_issue(0); set_wb(0, 0, 64'hFF); #1;
         n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready%0d got=%b exp=1", i, bus.issue_ready); end
         tick();
      end
      idle(); set_rd(0, 0); set_rd(1, 0); #1;
      n_checks++; if (bus.rd_data !== 128'd0) begin n_fail++; $display("FAIL x0_data got=%h exp=0", bus.rd_data); end
      n_checks++; if (bus.rd_busy !== 2'b00) begin n_fail++; $display("FAIL x0_busy got=%b exp=00", bus.rd_busy); end
      n_checks++; if (bus.write_complete !== 1'b1) begin n_fail++; $display("FAIL x0_wc got=%b exp=1", bus.write_complete); end
      tick(); #1;
      n_checks++; if (bus.write_complete !== 1'b0) begin n_fail++; $display("FAIL wc_clear got=%b exp=0", bus.write_complete); end
   endtask

   task automatic test_random();
      bit exp_raw;
      for (int c = 0; c < 400; c++) begin
         idle();
         for (int p = 0; p < NRD; p++) begin
            set_rd(p, rand_addr());
            bus.rd_en[p] = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 3) != 0) set_issue(rand_addr());
         for (int w = 0; w < NWB; w++)
            if ($urandom_range(0, 3) == 0) set_wb(w, rand_addr(), {$urandom, $urandom});
         bus.flush = ($urandom_range(0, 24) == 0);
         #1;
         exp_raw = 1'b0;
         for (int p = 0; p < NRD; p++) begin
            int a = int'(bus.rd_addr[p*AW +: AW]);
            n_checks++; if (bus.rd_data[p*DW +: DW] !== exp_data(a)) begin n_fail++; $display("FAIL rnd_data c%0d p%0d x%0d got=%h exp=%h", c, p, a, bus.rd_data[p*DW +: DW], exp_data(a)); end
            n_checks++; if (bus.rd_busy[p] !== exp_busy(a)) begin n_fail++; $display("FAIL rnd_busy c%0d p%0d x%0d got=%b exp=%b", c, p, a, bus.rd_busy[p], exp_busy(a)); end
            if (bus.rd_en[p] && exp_busy(a)) exp_raw = 1'b1;
         end
         n_checks++; if (bus.raw_dependency !== exp_raw) begin n_fail++; $display("FAIL rnd_raw c%0d got=%b exp=%b", c, bus.raw_dependency, exp_raw); end
         n_checks++; if (bus.issue_ready !== m_issue_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, bus.issue_ready, m_issue_ready()); end
         n_checks++; if (bus.write_complete !== m_wc) begin n_fail++; $display("FAIL rnd_wc c%0d got=%b exp=%b", c, bus.write_complete, m_wc); end
         tick();
      end
   endtask

   initial begin
      reset        = 1'b1;
      stackptr     = '0;
      bus.rd_addr  = '0;
      bus.wb_addr  = '0;
      bus.wb_data  = '0;
      idle();
      test_reset();
      test_issue_saturation();
      test_same_edge();
      test_bypass();
      test_flush();
      test_x0();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
